// File: rtl/in_rom_arbiter_if.sv
// Bus bundle between the two ROM requesters (gen_message_random = 0,
// hash_message = 1), the shared ROM and the arbiter.
//   gen_*/hash_*  : per-requester burst request, grant, valid and done
//   rd_data       : read data returned to whichever requester owns the bus
//   mem_*         : ROM read port (data arrives one cycle after mem_ren)
//   busy          : arbiter is not idle
// Modports: slave = arbiter side, master = requesters + ROM side.
interface in_rom_arbiter_if #(
    parameter int unsigned MEM_ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH     = 256
);
    logic                      gen_req;
    logic [MEM_ADDR_WIDTH-1:0] gen_addr;
    logic [MEM_ADDR_WIDTH-1:0] gen_len;
    logic                      hash_req;
    logic [MEM_ADDR_WIDTH-1:0] hash_addr;
    logic [MEM_ADDR_WIDTH-1:0] hash_len;
    logic                      gen_gnt;
    logic                      hash_gnt;
    logic                      gen_vld;
    logic                      hash_vld;
    logic                      gen_done;
    logic                      hash_done;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      mem_ren;
    logic [MEM_ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0]     mem_dout;
    logic                      busy;

    modport slave (
        input  gen_req, gen_addr, gen_len, hash_req, hash_addr, hash_len, mem_dout,
        output gen_gnt, hash_gnt, gen_vld, hash_vld, gen_done, hash_done, rd_data,
               mem_ren, mem_raddr, busy
    );

    modport master (
        output gen_req, gen_addr, gen_len, hash_req, hash_addr, hash_len, mem_dout,
        input  gen_gnt, hash_gnt, gen_vld, hash_vld, gen_done, hash_done, rd_data,
               mem_ren, mem_raddr, busy
    );
endinterface

// File: rtl/in_rom_arbiter.sv
// Round-robin arbiter giving two requesters burst access to one ROM read port.
// A burst reads len+1 consecutive words (address wraps) with no bubbles; the
// owner sees gnt for the whole burst, vld one cycle after each read and a
// one-cycle done pulse together with the last data word.
// Ports:
//   clk  : clock, all state on rising edge
//   rstn : asynchronous active-low reset
//   bus  : in_rom_arbiter_if slave modport (requests, grants, ROM port)
module in_rom_arbiter #(
    parameter int unsigned MEM_ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH     = 256
) (
    input  logic               clk,
    input  logic               rstn,
    in_rom_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                      owner_q, owner_d;  // 0 = gen, 1 = hash
    logic                      last_q, last_d;    // owner of last completed burst
    logic                      ren_q;             // mem_ren delayed: data valid
    logic                      win;
    logic                      ren;
    logic [DATA_WIDTH-1:0]     rd_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;  // gen wins the first tie
            ren_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ren_q   <= ren;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        // On a tie the requester that did not own the last burst wins.
        win     = (bus.gen_req && bus.hash_req) ? ~last_q : bus.hash_req;
        unique case (state_q)
            StIdle: begin
                if (bus.gen_req || bus.hash_req) begin
                    owner_d = win;
                    addr_d  = win ? bus.hash_addr : bus.gen_addr;
                    cnt_d   = win ? bus.hash_len : bus.gen_len;
                    state_d = StRead;
                end
            end
            StRead: begin
                addr_d = addr_q + 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDrain: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ren           = 1'b0;
        bus.mem_raddr = '0;
        bus.gen_gnt   = 1'b0;
        bus.hash_gnt  = 1'b0;
        bus.gen_done  = 1'b0;
        bus.hash_done = 1'b0;
        bus.busy      = (state_q != StIdle);
        unique case (state_q)
            StRead: begin
                ren           = 1'b1;
                bus.mem_raddr = addr_q;
                bus.gen_gnt   = ~owner_q;
                bus.hash_gnt  = owner_q;
            end
            StDrain: begin
                bus.gen_gnt   = ~owner_q;
                bus.hash_gnt  = owner_q;
                bus.gen_done  = ~owner_q;
                bus.hash_done = owner_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_ren  = ren;
    assign bus.gen_vld  = ren_q & ~owner_q;
    assign bus.hash_vld = ren_q & owner_q;
    assign rd_data      = bus.mem_dout;
    assign bus.rd_data  = rd_data;

endmodule

// File: tb/tb_in_rom_arbiter.sv
// Bench for in_rom_arbiter: a ROM model answers reads, a scoreboard holds the
// expected read addresses and returned words in issue order.
module tb_in_rom_arbiter;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 256;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    in_rom_arbiter_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    in_rom_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int gen_done_cnt = 0;
    int hash_done_cnt = 0;
    int exp_gen_done = 0;
    int exp_hash_done = 0;
    logic [AW-1:0] exp_addr_q[$];
    exp_t          exp_data_q[$];

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {8{a, 1'b1, 24'hC0FFEE ^ {17'd0, a}}};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_dout <= rom_word(bus.mem_raddr);
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            exp_t e;
            check_eq("one_gnt", bus.gen_gnt & bus.hash_gnt, 0);
            if (bus.mem_ren) begin
                if (exp_addr_q.size() == 0) check_eq("raddr_unexpected", bus.mem_ren, 0);
                else check_eq("raddr", bus.mem_raddr, exp_addr_q.pop_front());
            end
            if (bus.gen_vld || bus.hash_vld) begin
                if (exp_data_q.size() == 0) begin
                    check_eq("vld_unexpected", {bus.hash_vld, bus.gen_vld}, 0);
                end else begin
                    e = exp_data_q.pop_front();
                    check_eq("vld_owner", {bus.hash_vld, bus.gen_vld},
                             (e.id == 1) ? 2'b10 : 2'b01);
                    check_eq("rd_data", bus.rd_data, rom_word(e.addr));
                end
            end
            if (bus.gen_done) gen_done_cnt++;
            if (bus.hash_done) hash_done_cnt++;
        end
    end

    task automatic drive_req(input int id, input logic req, input logic [AW-1:0] addr,
                             input logic [AW-1:0] len);
        if (id == 0) begin
            bus.gen_req = req; bus.gen_addr = addr; bus.gen_len = len;
        end else begin
            bus.hash_req = req; bus.hash_addr = addr; bus.hash_len = len;
        end
    endtask

    task automatic push_burst(input int id, input logic [AW-1:0] addr,
                              input logic [AW-1:0] len);
        exp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.addr = addr + AW'(i);
            exp_addr_q.push_back(e.addr);
            exp_data_q.push_back(e);
        end
    endtask

    // Grant and first read must appear one cycle after the IDLE sample edge.
    task automatic wait_gnt(input string tag, input int id);
        @(posedge clk); #1;
        check_eq(tag, {bus.hash_gnt, bus.gen_gnt, bus.mem_ren}, (id == 1) ? 3'b101 : 3'b011);
    endtask

    // Counts edges until the owner's done; then checks the return to IDLE.
    task automatic wait_done(input string tag, input int id, input int exp_k);
        int k = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            k++;
            if ((id == 0 && bus.gen_done) || (id == 1 && bus.hash_done)) break;
        end
        check_eq(tag, k, exp_k);
        if (id == 0) exp_gen_done++; else exp_hash_done++;
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic burst(input string tag, input int id, input logic [AW-1:0] addr,
                         input logic [AW-1:0] len);
        drive_req(id, 1'b1, addr, len);
        push_burst(id, addr, len);
        wait_gnt({tag, "_gnt"}, id);
        drive_req(id, 1'b0, ~addr, ~len);  // must be ignored mid-burst
        wait_done({tag, "_done"}, id, int'(len) + 1);
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq(tag, {bus.gen_gnt, bus.hash_gnt, bus.gen_vld, bus.hash_vld, bus.gen_done,
                       bus.hash_done, bus.mem_ren, bus.busy, bus.mem_raddr}, 0);
    endtask

    task automatic tie(input string tag, input logic [AW-1:0] ga, input logic [AW-1:0] gl,
                       input logic [AW-1:0] ha, input logic [AW-1:0] hl);
        drive_req(0, 1'b1, ga, gl);
        drive_req(1, 1'b1, ha, hl);
        push_burst(0, ga, gl);
        push_burst(1, ha, hl);
        wait_gnt({tag, "_gen_gnt"}, 0);
        drive_req(0, 1'b0, 0, 0);
        wait_done({tag, "_gen_done"}, 0, int'(gl) + 1);
        wait_gnt({tag, "_hash_gnt"}, 1);
        drive_req(1, 1'b0, 0, 0);
        wait_done({tag, "_hash_done"}, 1, int'(hl) + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int saved_done;
        drive_req(0, 1'b0, 0, 0);
        drive_req(1, 1'b0, 0, 0);
        bus.mem_dout = '0;
        #12;
        check_outs_zero("reset_outs");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check_outs_zero("idle_after_reset");

        burst("b_gen_0_1", 0, 7'd0, 7'd1);
        burst("b_hash_wrap", 1, 7'd126, 7'd3);
        tie("tie1", 7'd10, 7'd2, 7'd20, 7'd1);
        tie("tie3", 7'd30, 7'd0, 7'd40, 7'd0);

        // gen burst, requester drops req early, hash waits its turn
        drive_req(0, 1'b1, 7'd50, 7'd5);
        push_burst(0, 7'd50, 7'd5);
        wait_gnt("noabort_gen_gnt", 0);
        repeat (2) @(posedge clk);
        #1;
        drive_req(0, 1'b0, 7'd99, 7'd99);
        drive_req(1, 1'b1, 7'd60, 7'd2);
        push_burst(1, 7'd60, 7'd2);
        wait_done("noabort_gen_done", 0, 4);
        wait_gnt("noabort_hash_gnt", 1);
        drive_req(1, 1'b0, 0, 0);
        wait_done("noabort_hash_done", 1, 3);

        // single-word bursts back to back; gen ends as last owner
        burst("single_gen", 0, 7'd70, 7'd0);
        burst("single_hash", 1, 7'd72, 7'd0);
        burst("single_gen2", 0, 7'd71, 7'd0);

        // reset mid-burst
        drive_req(0, 1'b1, 7'd80, 7'd10);
        push_burst(0, 7'd80, 7'd10);
        wait_gnt("rst_gen_gnt", 0);
        repeat (3) @(posedge clk);
        #1;
        saved_done = gen_done_cnt + hash_done_cnt;
        rstn = 1'b0;
        #1;
        check_outs_zero("midburst_reset_outs");
        exp_addr_q.delete();
        exp_data_q.delete();
        drive_req(0, 1'b0, 0, 0);
        @(posedge clk); #1;
        check_outs_zero("held_reset_outs");
        rstn = 1'b1;
        @(posedge clk); #1;
        check_eq("no_done_on_reset", gen_done_cnt + hash_done_cnt, saved_done);
        // pointer restored: gen wins the tie even though gen owned the last burst
        tie("tie_after_reset", 7'd90, 7'd1, 7'd100, 7'd2);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", exp_addr_q.size() + exp_data_q.size(), 0);
        check_eq("gen_done_cnt", gen_done_cnt, exp_gen_done);
        check_eq("hash_done_cnt", hash_done_cnt, exp_hash_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
